star_region_eraser: RTL and testbench
=====================================

Name: star_region_eraser

Overview:
- Writer-side companion to the top/bottom star finder. Takes a found star's bounding box (left, right, top, bottom) and overwrites every pixel inside it in the 60x60, 3-bit image RAM with the background value.
- The next star search then cannot re-detect the same star.
- Sits between the star-measurement FSMs and the image RAM write port. Arbitrates for that port with a request/grant handshake.

Parameters:
- xSz, 6, x coordinate width
- ySz, 6, y coordinate width
- addrSz, 12, RAM address width
- colSz, 3, pixel width
- X_RES, 60, image width in pixels
- Y_RES, 60, image height in pixels
- CLEAR_VAL, 0, value written to erased pixels (matches the finder's black threshold)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch box and begin erase
- leftMost  in  xSz  box left column (inclusive)
- rightMost  in  xSz  box right column (inclusive)
- mostTop  in  ySz  box top row (inclusive)
- mostBottom  in  ySz  box bottom row (inclusive)
- memGnt  in  1  write port granted this cycle
- memReq  out  1  requesting RAM write port
- wren  out  1  RAM write enable (memReq & memGnt)
- wrAddress  out  addrSz  RAM address = y*X_RES + x
- wrData  out  colSz  always CLEAR_VAL
- busy  out  1  high from the cycle after start until done
- eraseDone  out  1  one-cycle completion pulse
- boxError  out  1  registered; set when the latched box was empty after clamping, cleared on next start

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; memReq, wren, busy, eraseDone, boxError = 0; counters = 0.
  - Outputs drop immediately, mid-erase included. No partial-write resume.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 latches all four coordinates into registers; -> LOAD.
  - Inputs are ignored outside IDLE; start while busy is dropped.
- LOAD (1 cycle):
  - Clamp rightMost to X_RES-1 and mostBottom to Y_RES-1.
  - Clamp leftMost/mostTop the same way.
  - If left>right or top>bottom after clamping: boxError=1, no writes, -> DONE.
  - Else: xCount=left, yCount=top, -> WRITE.
- WRITE:
  - memReq=1.
  - wrAddress is computed combinationally from (xCount, yCount) via shift-add: y*32 + y*16 + y*8 + y*4 + x, unsigned, zero-extended operands.
  - Cycle with memGnt=1: wren=1, one pixel written. Then:
    - if xCount==right and yCount==bottom: -> DONE;
    - else if xCount==right: xCount=left, yCount+1;
    - else xCount+1.
  - Cycle with memGnt=0: wren=0, counters hold, address stable.
- DONE (1 cycle): eraseDone=1, memReq=0; -> IDLE. busy=0 in IDLE.
- Latency and write count:
  - start at cycle N; first possible write at cycle N+2.
  - Full grant: exactly (right-left+1)*(bottom-top+1) writes on consecutive cycles.
  - eraseDone asserts the cycle after the last write.
- Each pixel in the box is written exactly once, raster order. No address outside the box is ever driven with wren=1.
- Max address 3599; counters never exceed clamped bounds, so no wrap-around.
- start coincident with reset release: ignored unless resetn=1 at that edge.

Test Plan:
- Box L=10,R=12,T=5,B=6, memGnt=1 constant:
  - 6 writes at addresses 310,311,312,370,371,372, wrData=0;
  - eraseDone exactly 1 cycle after the 6th write; busy low after.
- Same box, memGnt toggling 1,0,1,0…:
  - still exactly 6 writes in the same order;
  - wrAddress stable during gnt=0 cycles; wren never high when memGnt=0.
- Single pixel L=R=59, T=B=59:
  - one write at address 3599, then eraseDone.
- Out-of-range box R=63, B=62, L=58, T=58:
  - clamped to 58..59 x 58..59;
  - 4 writes (3538,3539,3598,3599).
- Empty box L=20,R=10:
  - no wren; boxError=1; eraseDone pulses 2 cycles after start.
- Reset mid-erase:
  - assert resetn=0 after 3 writes of a 10-pixel box → wren/memReq/busy go 0 asynchronously;
  - after release, no writes until a new start.
- start pulsed again while busy: ignored; write count for the original box unchanged.

Source files
------------

// File: rtl/star_region_eraser.sv
// Erases a star's bounding box in the 60x60 image RAM by writing CLEAR_VAL to every pixel
// inside the clamped box, in raster order, through a request/grant shared write port.
module star_region_eraser #(
    parameter int xSz       = 6,
    parameter int ySz       = 6,
    parameter int addrSz    = 12,
    parameter int colSz     = 3,
    parameter int X_RES     = 60,
    parameter int Y_RES     = 60,
    parameter int CLEAR_VAL = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [xSz-1:0]    leftMost,
    input  logic [xSz-1:0]    rightMost,
    input  logic [ySz-1:0]    mostTop,
    input  logic [ySz-1:0]    mostBottom,
    input  logic              memGnt,
    output logic              memReq,
    output logic              wren,
    output logic [addrSz-1:0] wrAddress,
    output logic [colSz-1:0]  wrData,
    output logic              busy,
    output logic              eraseDone,
    output logic              boxError
);

    localparam logic [xSz-1:0] X_MAX = xSz'(X_RES - 1);
    localparam logic [ySz-1:0] Y_MAX = ySz'(Y_RES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [xSz-1:0] left_q, right_q, x_count_q;
    logic [ySz-1:0] top_q, bottom_q, y_count_q;
    logic           mem_req_q, busy_q, erase_done_q, box_error_q;

    // Clamped view of the latched box, consumed only in LOAD.
    logic [xSz-1:0] left_d, right_d;
    logic [ySz-1:0] top_d, bottom_d;
    logic           empty_d;

    always_comb begin
        left_d   = (left_q   > X_MAX) ? X_MAX : left_q;
        right_d  = (right_q  > X_MAX) ? X_MAX : right_q;
        top_d    = (top_q    > Y_MAX) ? Y_MAX : top_q;
        bottom_d = (bottom_q > Y_MAX) ? Y_MAX : bottom_q;
        empty_d  = (left_d > right_d) || (top_d > bottom_d);
    end

    // y*60 + x as y*(32+16+8+4) + x; counters stay inside the clamped box so no overflow.
    logic [addrSz-1:0] addr_x, addr_y;

    always_comb begin
        addr_x    = addrSz'(x_count_q);
        addr_y    = addrSz'(y_count_q);
        wrAddress = (addr_y << 5) + (addr_y << 4) + (addr_y << 3) + (addr_y << 2) + addr_x;
    end

    assign memReq    = mem_req_q;
    assign wren      = mem_req_q & memGnt;
    assign wrData    = colSz'(CLEAR_VAL);
    assign busy      = busy_q;
    assign eraseDone = erase_done_q;
    assign boxError  = box_error_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            left_q       <= '0;
            right_q      <= '0;
            top_q        <= '0;
            bottom_q     <= '0;
            x_count_q    <= '0;
            y_count_q    <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            erase_done_q <= 1'b0;
            box_error_q  <= 1'b0;
        end else begin
            erase_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        left_q      <= leftMost;
                        right_q     <= rightMost;
                        top_q       <= mostTop;
                        bottom_q    <= mostBottom;
                        box_error_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (empty_d) begin
                        box_error_q  <= 1'b1;
                        erase_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        left_q    <= left_d;
                        right_q   <= right_d;
                        top_q     <= top_d;
                        bottom_q  <= bottom_d;
                        x_count_q <= left_d;
                        y_count_q <= top_d;
                        mem_req_q <= 1'b1;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    // Without a grant nothing moves, so the address stays put for the retry.
                    if (memGnt) begin
                        if (x_count_q == right_q && y_count_q == bottom_q) begin
                            mem_req_q    <= 1'b0;
                            erase_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else if (x_count_q == right_q) begin
                            x_count_q <= left_q;
                            y_count_q <= y_count_q + ySz'(1);
                        end else begin
                            x_count_q <= x_count_q + xSz'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_region_eraser.sv
// Randomised and directed checks of star_region_eraser against a box-to-address-list model.
module tb_star_region_eraser;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  leftMost = '0, rightMost = '0, mostTop = '0, mostBottom = '0;
    logic        memGnt = 1'b0;
    logic        memReq, wren, busy, eraseDone, boxError;
    logic [11:0] wrAddress;
    logic [2:0]  wrData;

    star_region_eraser dut (
        .clk(clk), .resetn(resetn), .start(start),
        .leftMost(leftMost), .rightMost(rightMost), .mostTop(mostTop), .mostBottom(mostBottom),
        .memGnt(memGnt), .memReq(memReq), .wren(wren), .wrAddress(wrAddress), .wrData(wrData),
        .busy(busy), .eraseDone(eraseDone), .boxError(boxError)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int exp_addr[$];
    int obs_addr[$];
    int last_wr_c, done_c, bad_wren, bad_data, bad_stable, busy_low;
    bit timed_out, err_at_done, busy_after, done_after;

    // Reference: clamp each edge to the image, then list pixels row by row.
    task automatic build_expected(input int l, input int r, input int t, input int b);
        int lc, rc, tc, bc;
        lc = (l > 59) ? 59 : l;
        rc = (r > 59) ? 59 : r;
        tc = (t > 59) ? 59 : t;
        bc = (b > 59) ? 59 : b;
        exp_addr.delete();
        for (int y = tc; y <= bc; y++)
            for (int x = lc; x <= rc; x++)
                exp_addr.push_back(y * 60 + x);
    endtask

    // Drives one erase and records what the DUT did; the test tasks judge the record.
    // mode 0: grant always, 1: grant on even cycles, 2: random grant.
    task automatic run_erase(input int l, input int r, input int t, input int b,
                             input int mode, input int restart_c);
        int budget;
        bit prev_hold;
        int prev_addr;
        build_expected(l, r, t, b);
        budget = 8 * exp_addr.size() + 20;
        obs_addr.delete();
        last_wr_c = 0; done_c = 0; bad_wren = 0; bad_data = 0; bad_stable = 0; busy_low = 0;
        timed_out = 0; err_at_done = 0; prev_hold = 0; prev_addr = 0;
        @(negedge clk);
        leftMost = 6'(l); rightMost = 6'(r); mostTop = 6'(t); mostBottom = 6'(b);
        start = 1'b1; memGnt = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            if (c == restart_c) begin
                leftMost = 6'd0; rightMost = 6'd40; mostTop = 6'd0; mostBottom = 6'd40;
            end
            case (mode)
                0:       memGnt = 1'b1;
                1:       memGnt = (c % 2 == 0);
                default: memGnt = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (!busy) busy_low++;
            if (wren) begin
                obs_addr.push_back(int'(wrAddress));
                last_wr_c = c;
                if (wrData !== 3'd0) bad_data++;
            end
            if (wren !== (memReq & memGnt)) bad_wren++;
            if (wren && !memGnt) bad_wren++;
            if (prev_hold && memReq && int'(wrAddress) != prev_addr) bad_stable++;
            prev_hold = memReq && !memGnt;
            prev_addr = int'(wrAddress);
            if (eraseDone) begin
                done_c = c;
                err_at_done = boxError;
                break;
            end
        end
        start = 1'b0;
        if (done_c == 0) timed_out = 1;
        @(negedge clk);
        memGnt = 1'b0;
        #1;
        busy_after = busy;
        done_after = eraseDone;
    endtask

    task automatic check_list(input string name);
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL %s_timeout: eraseDone never seen, required within budget", name);
        end
        vectors++;
        if (obs_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, obs_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                vectors++;
                if (obs_addr[i] != exp_addr[i]) begin
                    miscompares++;
                    $display("FAIL %s_addr[%0d]: got %0d, required %0d", name, i, obs_addr[i], exp_addr[i]);
                end
            end
        end
        vectors++;
        if (bad_wren != 0 || bad_data != 0 || busy_low != 0) begin
            miscompares++;
            $display("FAIL %s_ctrl: bad_wren=%0d bad_data=%0d busy_low=%0d, required all 0",
                     name, bad_wren, bad_data, busy_low);
        end
        vectors++;
        if (busy_after !== 1'b0 || done_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after: busy=%b eraseDone=%b, required 0 0", name, busy_after, done_after);
        end
    endtask

    task automatic test_reset();
        start = 1'b1; leftMost = 6'd1; rightMost = 6'd2; mostTop = 6'd1; mostBottom = 6'd2;
        memGnt = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({memReq, wren, busy, eraseDone, boxError} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required 00000", {memReq, wren, busy, eraseDone, boxError});
        end
        start = 1'b0; memGnt = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        run_erase(10, 12, 5, 6, 0, 0);
        check_list("basic");
        vectors++;
        if (done_c != 8 || done_c != last_wr_c + 1) begin
            miscompares++;
            $display("FAIL basic_latency: done at %0d last write %0d, required 8 and 7", done_c, last_wr_c);
        end
        vectors++;
        if (err_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_boxerr: got %b, required 0", err_at_done);
        end
    endtask

    task automatic test_toggle();
        run_erase(10, 12, 5, 6, 1, 0);
        check_list("toggle");
        vectors++;
        if (bad_stable != 0 || done_c != last_wr_c + 1) begin
            miscompares++;
            $display("FAIL toggle_stable: unstable=%0d done=%0d last=%0d, required 0 and done=last+1",
                     bad_stable, done_c, last_wr_c);
        end
    endtask

    task automatic test_corner();
        run_erase(59, 59, 59, 59, 0, 0);
        check_list("corner");
        vectors++;
        if (done_c != 3) begin
            miscompares++;
            $display("FAIL corner_done: got cycle %0d, required 3", done_c);
        end
    endtask

    task automatic test_clamp();
        run_erase(58, 63, 58, 62, 0, 0);
        check_list("clamp");
    endtask

    task automatic test_empty();
        run_erase(20, 10, 5, 6, 0, 0);
        check_list("empty");
        vectors++;
        if (done_c != 2 || err_at_done !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_done: cycle=%0d boxError=%b, required 2 and 1", done_c, err_at_done);
        end
        vectors++;
        if (boxError !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_sticky: boxError=%b, required 1", boxError);
        end
        run_erase(3, 4, 7, 7, 0, 0);
        check_list("after_empty");
        vectors++;
        if (err_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL after_empty_boxerr: got %b, required 0", err_at_done);
        end
    endtask

    task automatic test_reset_mid();
        int nw;
        nw = 0;
        @(negedge clk);
        leftMost = 6'd0; rightMost = 6'd9; mostTop = 6'd0; mostBottom = 6'd0;
        start = 1'b1;
        for (int c = 1; c <= 40 && nw < 3; c++) begin
            @(negedge clk);
            start = 1'b0; memGnt = 1'b1;
            #1;
            if (wren) nw++;
        end
        vectors++;
        if (nw != 3) begin
            miscompares++;
            $display("FAIL midreset_pre: got %0d writes, required 3", nw);
        end
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({wren, memReq, busy, eraseDone} !== 4'b0) begin
            miscompares++;
            $display("FAIL midreset_async: wren/memReq/busy/done=%b, required 0000",
                     {wren, memReq, busy, eraseDone});
        end
        @(negedge clk);
        resetn = 1'b1;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            memGnt = 1'b1;
            #1;
            if (wren || busy) nw++;
        end
        memGnt = 1'b0;
        vectors++;
        if (nw != 0) begin
            miscompares++;
            $display("FAIL midreset_resume: got %0d active cycles, required 0", nw);
        end
    endtask

    task automatic test_busy_start();
        run_erase(10, 14, 5, 6, 0, 3);
        check_list("busy_start");
        run_erase(30, 31, 40, 41, 2, 5);
        check_list("busy_start_rnd");
    endtask

    task automatic test_random();
        int l, r, t, b;
        for (int i = 0; i < 12; i++) begin
            l = $urandom_range(0, 63);
            t = $urandom_range(0, 63);
            r = l + $urandom_range(0, 5) - (($urandom_range(0, 7) == 0) ? 7 : 0);
            b = t + $urandom_range(0, 4);
            if (r > 63) r = 63;
            if (r < 0) r = 0;
            if (b > 63) b = 63;
            run_erase(l, r, t, b, 2, 0);
            check_list("random");
            vectors++;
            if (bad_stable != 0 || err_at_done !== (exp_addr.size() == 0)) begin
                miscompares++;
                $display("FAIL random_box L=%0d R=%0d T=%0d B=%0d: unstable=%0d boxError=%b",
                         l, r, t, b, bad_stable, err_at_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_corner();
        test_clamp();
        test_empty();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
